// File: rtl/fir_coeff_sequencer_if.sv
// Coefficient port bundle between the sequencer and fir_filter.
//   coeff_wr   : write strobe for one tap
//   coeff_addr : tap index
//   coeff_data : tap value
//   coeff_ld   : one-cycle pulse that makes the newly written bank active
// master = fir_coeff_sequencer (driver), slave = fir_filter (receiver).
interface fir_coeff_sequencer_if #(
  parameter int unsigned COEFF_WIDTH = 18
) ();

  logic                   coeff_wr;
  logic [7:0]             coeff_addr;
  logic [COEFF_WIDTH-1:0] coeff_data;
  logic                   coeff_ld;

  modport master (
    output coeff_wr,
    output coeff_addr,
    output coeff_data,
    output coeff_ld
  );

  modport slave (
    input coeff_wr,
    input coeff_addr,
    input coeff_data,
    input coeff_ld
  );

endinterface

// File: rtl/fir_coeff_sequencer.sv
// Owns the coefficient port of fir_filter. The host fills a shadow bank while
// idle; a commit gates the upstream sample stream, waits for the filter to
// drain, streams the bank into the filter one tap per cycle, pulses coeff_ld
// and releases the stream.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   host_wr/addr/data         : shadow bank write (accepted only while idle)
//   host_ready                : high only while idle
//   cmd_commit                : single-cycle load request
//   err_clr                   : clears the sticky error flags
//   up_valid / up_ready       : upstream sample handshake (gated)
//   fir_data_valid/ready      : filter sample handshake (gated)
//   fir_busy                  : filter processing or mac_valid
//   fir_enable                : filter enable, held high
//   coeff_if                  : coefficient port towards the filter
//   load_done                 : one-cycle pulse when a load completes
//   gen_count                 : number of completed loads, wraps at 256
//   err_addr/timeout/busy     : sticky error flags
module fir_coeff_sequencer #(
  parameter int unsigned COEFF_WIDTH   = 18,
  parameter int unsigned NUM_TAPS      = 64,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_wr,
  input  logic [7:0]             host_addr,
  input  logic [COEFF_WIDTH-1:0] host_data,
  output logic                   host_ready,
  input  logic                   cmd_commit,
  input  logic                   err_clr,
  input  logic                   up_valid,
  output logic                   up_ready,
  output logic                   fir_data_valid,
  input  logic                   fir_data_ready,
  input  logic                   fir_busy,
  output logic                   fir_enable,
  fir_coeff_sequencer_if.master  coeff_if,
  output logic                   load_done,
  output logic [7:0]             gen_count,
  output logic                   err_addr,
  output logic                   err_timeout,
  output logic                   err_busy
);

  localparam int unsigned AW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_LOAD   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [COEFF_WIDTH-1:0] shadow_q [NUM_TAPS];

  logic             gate_q, gate_d;
  logic             quiet_q, quiet_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]       idx_q, idx_d;

  logic                   coeff_wr_q, coeff_wr_d;
  logic [7:0]             coeff_addr_q, coeff_addr_d;
  logic [COEFF_WIDTH-1:0] coeff_data_q, coeff_data_d;
  logic                   coeff_ld_q, coeff_ld_d;
  logic                   load_done_q, load_done_d;
  logic [7:0]             gen_count_q, gen_count_d;
  logic                   host_ready_q, host_ready_d;
  logic                   fir_enable_q;
  logic                   err_addr_q, err_addr_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   err_busy_q, err_busy_d;

  logic             in_idle;
  logic             addr_ok;
  logic             shadow_we;
  logic             drain_exit;
  logic             drain_expire;
  logic             last_idx;
  logic [CNT_W-1:0] drain_cnt_inc;

  // Shared decodes
  assign in_idle       = (state_q == S_IDLE);
  assign addr_ok       = ({1'b0, host_addr} < 9'(NUM_TAPS));
  assign shadow_we     = in_idle & host_wr & addr_ok;
  assign drain_cnt_inc = drain_cnt_q + CNT_W'(1);
  // Filter status lags one register, so require two quiet cycles in a row
  assign drain_exit    = (state_q == S_DRAIN) & ~fir_busy & quiet_q;
  assign drain_expire  = (state_q == S_DRAIN) & (drain_cnt_inc == CNT_W'(DRAIN_TIMEOUT));
  assign last_idx      = (idx_q == 8'(NUM_TAPS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a successful drain wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_commit) state_d = S_DRAIN;
      S_DRAIN: begin
        if (drain_exit) begin
          state_d = S_LOAD;
        end else if (drain_expire) begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:   if (last_idx) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs follow the state being entered
  always_comb begin
    gate_d        = (state_d != S_IDLE);
    quiet_d       = quiet_q;
    drain_cnt_d   = drain_cnt_q;
    idx_d         = idx_q;
    coeff_wr_d    = 1'b0;
    coeff_addr_d  = coeff_addr_q;
    coeff_data_d  = coeff_data_q;
    coeff_ld_d    = 1'b0;
    load_done_d   = 1'b0;
    gen_count_d   = gen_count_q;
    host_ready_d  = (state_d == S_IDLE);
    err_addr_d    = err_addr_q & ~err_clr;
    err_timeout_d = err_timeout_q & ~err_clr;
    err_busy_d    = err_busy_q & ~err_clr;

    if (in_idle && cmd_commit) begin
      quiet_d     = 1'b0;
      drain_cnt_d = '0;
    end

    if (state_q == S_DRAIN) begin
      quiet_d     = ~fir_busy;
      drain_cnt_d = drain_cnt_inc;
    end

    if (state_d == S_LOAD) begin
      idx_d        = (state_q == S_LOAD) ? (idx_q + 8'd1) : 8'd0;
      coeff_wr_d   = 1'b1;
      coeff_addr_d = idx_d;
      coeff_data_d = shadow_q[AW'(idx_d)];
    end

    if (state_d == S_COMMIT) begin
      coeff_ld_d  = 1'b1;
      load_done_d = 1'b1;
      gen_count_d = gen_count_q + 8'd1;
    end

    // A new error event overrides a same-cycle clear
    if (in_idle && host_wr && !addr_ok) err_addr_d = 1'b1;
    if (!in_idle && cmd_commit)         err_busy_d = 1'b1;
    if ((state_q == S_DRAIN) && (state_d == S_IDLE)) err_timeout_d = 1'b1;
  end

  // Shadow bank; cleared on reset so an aborted load leaves a known bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[AW'(host_addr)] <= host_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q        <= 1'b0;
      quiet_q       <= 1'b0;
      drain_cnt_q   <= '0;
      idx_q         <= '0;
      coeff_wr_q    <= 1'b0;
      coeff_addr_q  <= '0;
      coeff_data_q  <= '0;
      coeff_ld_q    <= 1'b0;
      load_done_q   <= 1'b0;
      gen_count_q   <= '0;
      host_ready_q  <= 1'b1;
      fir_enable_q  <= 1'b1;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_busy_q    <= 1'b0;
    end else begin
      gate_q        <= gate_d;
      quiet_q       <= quiet_d;
      drain_cnt_q   <= drain_cnt_d;
      idx_q         <= idx_d;
      coeff_wr_q    <= coeff_wr_d;
      coeff_addr_q  <= coeff_addr_d;
      coeff_data_q  <= coeff_data_d;
      coeff_ld_q    <= coeff_ld_d;
      load_done_q   <= load_done_d;
      gen_count_q   <= gen_count_d;
      host_ready_q  <= host_ready_d;
      fir_enable_q  <= 1'b1;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      err_busy_q    <= err_busy_d;
    end
  end

  // Stream gating is combinational from the registered gate
  assign up_ready       = fir_data_ready & ~gate_q;
  assign fir_data_valid = up_valid & ~gate_q;

  assign coeff_if.coeff_wr   = coeff_wr_q;
  assign coeff_if.coeff_addr = coeff_addr_q;
  assign coeff_if.coeff_data = coeff_data_q;
  assign coeff_if.coeff_ld   = coeff_ld_q;

  assign host_ready  = host_ready_q;
  assign fir_enable  = fir_enable_q;
  assign load_done   = load_done_q;
  assign gen_count   = gen_count_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;
  assign err_busy    = err_busy_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed/random bench for fir_coeff_sequencer with a behavioural model of
// the shadow bank, load timing, generation counter and error flags.
module tb_fir_coeff_sequencer;

  localparam int unsigned CW       = 18;
  localparam int unsigned NUM_TAPS = 64;
  localparam int unsigned DRAIN_TO = 16;

  logic          clk;
  logic          rst;
  logic          host_wr;
  logic [7:0]    host_addr;
  logic [CW-1:0] host_data;
  logic          host_ready;
  logic          cmd_commit;
  logic          err_clr;
  logic          up_valid;
  logic          up_ready;
  logic          fir_data_valid;
  logic          fir_data_ready;
  logic          fir_busy;
  logic          fir_enable;
  logic          load_done;
  logic [7:0]    gen_count;
  logic          err_addr;
  logic          err_timeout;
  logic          err_busy;

  fir_coeff_sequencer_if #(.COEFF_WIDTH(CW)) cif ();

  fir_coeff_sequencer #(
    .COEFF_WIDTH  (CW),
    .NUM_TAPS     (NUM_TAPS),
    .DRAIN_TIMEOUT(DRAIN_TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr       (host_wr),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .cmd_commit    (cmd_commit),
    .err_clr       (err_clr),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .fir_data_valid(fir_data_valid),
    .fir_data_ready(fir_data_ready),
    .fir_busy      (fir_busy),
    .fir_enable    (fir_enable),
    .coeff_if      (cif),
    .load_done     (load_done),
    .gen_count     (gen_count),
    .err_addr      (err_addr),
    .err_timeout   (err_timeout),
    .err_busy      (err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [CW-1:0] shadow_m [NUM_TAPS];
  logic [7:0]    gen_m;
  logic          err_addr_m;
  logic          err_timeout_m;
  logic          err_busy_m;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_TAPS); i++) shadow_m[i] = '0;
    gen_m         = 8'd0;
    err_addr_m    = 1'b0;
    err_timeout_m = 1'b0;
    err_busy_m    = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_addr"},    32'(err_addr),    32'(err_addr_m));
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'(err_timeout_m));
    check({tag, "_err_busy"},    32'(err_busy),    32'(err_busy_m));
  endtask

  task automatic host_write(input logic [7:0] a, input logic [CW-1:0] d);
    host_wr = 1'b1; host_addr = a; host_data = d;
    @(posedge clk); #1;
    host_wr = 1'b0;
    #1;
    if (int'(a) < int'(NUM_TAPS)) shadow_m[int'(a)] = d;
    else err_addr_m = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      up_valid = 1'($urandom); fir_data_ready = 1'($urandom);
      #1;
      check("idle_no_wr", 32'(cif.coeff_wr), 32'd0);
    end
  endtask

  // Commit (optionally with a same-cycle host write) and follow the whole load.
  // busy_len: fir_busy held high on cycles 1..busy_len after the commit.
  // inj: host write and a second commit during LOAD (both must be ignored).
  // abort_idx >= 0: assert reset when LOAD reaches that index.
  task automatic commit_and_check(input int busy_len, input bit wr_en, input logic [7:0] wr_addr,
                                  input logic [CW-1:0] wr_data, input bit inj, input int abort_idx);
    int load_start;
    int commit_cyc;
    int idle_cyc;
    int ea;
    bit loading;
    load_start = busy_len + 3;
    commit_cyc = load_start + int'(NUM_TAPS);
    idle_cyc   = commit_cyc + 1;
    host_wr = wr_en; host_addr = wr_addr; host_data = wr_data;
    cmd_commit = 1'b1; fir_busy = 1'b0;
    if (wr_en) begin
      if (int'(wr_addr) < int'(NUM_TAPS)) shadow_m[int'(wr_addr)] = wr_data;
      else err_addr_m = 1'b1;
    end
    for (int c = 1; c <= idle_cyc; c++) begin
      @(posedge clk); #1;
      host_wr = 1'b0; cmd_commit = 1'b0;
      fir_busy = (c <= busy_len);
      up_valid = 1'($urandom); fir_data_ready = 1'($urandom);
      if (inj && c == load_start + 5) begin
        host_wr = 1'b1; host_addr = 8'd3; host_data = CW'($urandom);
      end
      if (inj && c == load_start + 10) begin
        cmd_commit = 1'b1; err_busy_m = 1'b1;
      end
      #1;
      loading = (c >= load_start) && (c < commit_cyc);
      check("coeff_wr", 32'(cif.coeff_wr), 32'(loading));
      if (loading) begin
        ea = c - load_start;
        check("coeff_addr", 32'(cif.coeff_addr), 32'(ea));
        check("coeff_data", 32'(cif.coeff_data), 32'(shadow_m[ea]));
      end
      check("coeff_ld",   32'(cif.coeff_ld), 32'(c == commit_cyc));
      check("load_done",  32'(load_done),    32'(c == commit_cyc));
      check("host_ready", 32'(host_ready),   32'(c == idle_cyc));
      check("fir_enable", 32'(fir_enable),   32'd1);
      if (c <= commit_cyc) begin
        check("up_ready_gated",  32'(up_ready),       32'd0);
        check("fdv_gated",       32'(fir_data_valid), 32'd0);
      end else begin
        check("up_ready_open",   32'(up_ready),       32'(fir_data_ready));
        check("fdv_open",        32'(fir_data_valid), 32'(up_valid));
      end
      if (abort_idx >= 0 && c == load_start + abort_idx) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; fir_busy = 1'b0; host_wr = 1'b0; cmd_commit = 1'b0;
        #1;
        model_reset();
        check("abort_host_ready", 32'(host_ready),   32'd1);
        check("abort_coeff_wr",   32'(cif.coeff_wr), 32'd0);
        check("abort_coeff_ld",   32'(cif.coeff_ld), 32'd0);
        check("abort_gen_count",  32'(gen_count),    32'(gen_m));
        check("abort_up_ready",   32'(up_ready),     32'(fir_data_ready));
        check("abort_fdv",        32'(fir_data_valid), 32'(up_valid));
        check_flags("abort");
        return;
      end
    end
    gen_m = gen_m + 8'd1;
    check("gen_count", 32'(gen_count), 32'(gen_m));
    check_flags("commit");
  endtask

  // fir_busy stuck high: DRAIN aborts after DRAIN_TO cycles with nothing written
  task automatic timeout_check();
    cmd_commit = 1'b1; fir_busy = 1'b1;
    for (int c = 1; c <= int'(DRAIN_TO) + 1; c++) begin
      @(posedge clk); #1;
      cmd_commit = 1'b0; fir_busy = 1'b1;
      up_valid = 1'($urandom); fir_data_ready = 1'($urandom);
      #1;
      check("to_coeff_wr",   32'(cif.coeff_wr), 32'd0);
      check("to_host_ready", 32'(host_ready),   32'(c == int'(DRAIN_TO) + 1));
      if (c <= int'(DRAIN_TO)) begin
        check("to_up_ready_gated", 32'(up_ready),    32'd0);
        check("to_err_timeout_lo", 32'(err_timeout), 32'd0);
      end else begin
        check("to_up_ready_open",  32'(up_ready),    32'(fir_data_ready));
        check("to_err_timeout_hi", 32'(err_timeout), 32'd1);
      end
    end
    err_timeout_m = 1'b1;
    fir_busy = 1'b0;
    check("to_gen_unchanged", 32'(gen_count), 32'(gen_m));
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    #1;
    err_addr_m = 1'b0; err_timeout_m = 1'b0; err_busy_m = 1'b0;
    check_flags("clr");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; host_wr = 1'b0; host_addr = '0; host_data = '0;
    cmd_commit = 1'b0; err_clr = 1'b0; up_valid = 1'b0;
    fir_data_ready = 1'b0; fir_busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; up_valid = 1'b1; fir_data_ready = 1'b1;
    #1;

    // Reset state
    check("rst_host_ready", 32'(host_ready),     32'd1);
    check("rst_coeff_wr",   32'(cif.coeff_wr),   32'd0);
    check("rst_coeff_ld",   32'(cif.coeff_ld),   32'd0);
    check("rst_coeff_addr", 32'(cif.coeff_addr), 32'd0);
    check("rst_coeff_data", 32'(cif.coeff_data), 32'd0);
    check("rst_load_done",  32'(load_done),      32'd0);
    check("rst_gen_count",  32'(gen_count),      32'd0);
    check("rst_fir_enable", 32'(fir_enable),     32'd1);
    check("rst_up_ready",   32'(up_ready),       32'd1);
    check("rst_fdv",        32'(fir_data_valid), 32'd1);
    check_flags("rst");

    // Basic load: shadow[i] = i + 1, no busy
    for (int i = 0; i < int'(NUM_TAPS); i++) host_write(8'(i), CW'(i + 1));
    commit_and_check(0, 1'b0, 8'd0, '0, 1'b0, -1);
    idle_cycles(3);

    // Out-of-range write is dropped and flagged
    host_write(8'd64, 18'h2AAAA);
    check_flags("addr64");
    // Clear coinciding with a new address error keeps the flag set
    host_wr = 1'b1; host_addr = 8'd200; host_data = 18'h1; err_clr = 1'b1;
    @(posedge clk); #1;
    host_wr = 1'b0; err_clr = 1'b0;
    #1;
    err_addr_m = 1'b1;
    check_flags("clr_vs_err");
    clear_errors();

    // Random writes, busy drain of 10 cycles, ignored write and commit during LOAD
    for (int i = 0; i < 40; i++) host_write(8'($urandom_range(0, 79)), CW'($urandom));
    commit_and_check(10, 1'b0, 8'd0, '0, 1'b1, -1);
    idle_cycles(5);
    clear_errors();

    // Same-cycle write and commit
    commit_and_check(int'($urandom_range(0, 10)), 1'b1, 8'd5, 18'h3FFFF, 1'b0, -1);

    // Drain timeout and its clear
    timeout_check();
    check_flags("timeout");
    clear_errors();

    // A few random loads with random drain lengths
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) host_write(8'($urandom_range(0, 63)), CW'($urandom));
      commit_and_check(int'($urandom_range(0, 10)), 1'b1, 8'($urandom_range(0, 63)),
                       CW'($urandom), 1'b0, -1);
    end

    // Reset at LOAD index 20 aborts the load and clears shadow and counters
    commit_and_check(int'($urandom_range(0, 5)), 1'b0, 8'd0, '0, 1'b0, 20);

    // 256 loads from a cleared bank wrap the generation counter back to 0
    for (int k = 0; k < 256; k++) begin
      commit_and_check(int'($urandom_range(0, 3)), 1'b0, 8'd0, '0, 1'b0, -1);
    end
    check("gen_wrap", 32'(gen_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Controller that owns the coefficient port of `fir_filter`. The host writes a new coefficient set into a local shadow bank at any time while the block is idle. On a commit command the block stalls the upstream sample stream and waits for the filter to drain. It then streams the whole bank into the filter one tap per cycle, pulses `coeff_ld`, and releases the stream. It sits between the host register interface, the sample source and `fir_filter`.

## Interface
- `COEFF_WIDTH`, 18: coefficient width (matches filter).
- `NUM_TAPS`, 64: taps loaded per commit, 1..256.
- `DRAIN_TIMEOUT`, 1024: maximum DRAIN cycles before abort, 2..65535.

Ports:
- `clk`  in  1: one clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `host_wr`  in  1: shadow write strobe.
- `host_addr`  in  8: shadow address.
- `host_data`  in  COEFF_WIDTH: shadow write data.
- `host_ready`  out  1: high only in IDLE; writes are ignored otherwise.
- `cmd_commit`  in  1: single-cycle load request.
- `err_clr`  in  1: clears the sticky error flags.
- `up_valid`  in  1: sample valid from the source.
- `up_ready`  out  1: combinational, `fir_data_ready & ~gate`.
- `fir_data_valid`  out  1: combinational, `up_valid & ~gate`.
- `fir_data_ready`  in  1: filter `data_ready`.
- `fir_busy`  in  1: filter `status[3] | status[4]` (processing or mac_valid).
- `fir_enable`  out  1: filter enable.
- `coeff_wr`, `coeff_addr[7:0]`, `coeff_data[COEFF_WIDTH-1:0]`, `coeff_ld`  out: filter coefficient port.
- `load_done`  out  1: one-cycle pulse when a load completes.
- `gen_count`  out  8: completed loads, wraps 255->0.
- `err_addr`, `err_timeout`, `err_busy`  out  1 each: sticky error flags.

## Operation
- States: IDLE, DRAIN, LOAD, COMMIT.
- Reset:
  - State goes to IDLE and all shadow entries clear to 0.
  - `coeff_wr`, `coeff_ld`, `coeff_addr`, `coeff_data`, `load_done`, `gen_count` and the error flags go to 0.
  - `gate` (internal register) goes to 0 and `fir_enable` goes to 1.
- IDLE:
  - `host_wr` with `host_addr < NUM_TAPS` writes the shadow entry.
  - `host_wr` with `host_addr >= NUM_TAPS` is dropped and sets `err_addr`.
  - `cmd_commit` moves the block to DRAIN, sets `gate`=1 and clears the drain counter.
- DRAIN:
  - Exits to LOAD when `fir_busy`=0 on two consecutive cycles. Two cycles are needed because filter status lags by one register.
  - When the counter reaches `DRAIN_TIMEOUT`: set `err_timeout`, clear `gate`, return to IDLE. No coefficient is written.
- LOAD:
  - The index runs 0..NUM_TAPS-1, one per cycle.
  - Each cycle drives `coeff_wr`=1, `coeff_addr`=idx and `coeff_data`=shadow[idx] (combinational shadow read, registered outputs).
  - After the last index the block moves to COMMIT.
- COMMIT:
  - Drives `coeff_ld`=1 and `load_done`=1 for one cycle, and increments `gen_count`.
  - Clears `gate` and returns to IDLE.
- `fir_enable` stays 1 in every state; the filter is quiesced by `gate` only.
- `cmd_commit` outside IDLE is ignored and sets `err_busy`.
- `host_wr` outside IDLE is ignored. `host_ready`=0 signals this; no error flag is set.
- `host_wr` and `cmd_commit` in the same IDLE cycle: the write lands in the shadow first and is included in the load.
- `err_clr` clears all flags. If it coincides with a new error event, the flag stays set.
- Reset mid-DRAIN or mid-LOAD aborts the load. The next cycle is IDLE with `coeff_wr`=0 and `gate`=0. Filter coefficients may be partially updated; software recommits.

## Timing
- `cmd_commit` sampled at edge 0: `gate`=1 from cycle 1.
- Minimum latency when `fir_busy`=0 throughout:
  - Cycles 1-2: DRAIN.
  - Cycles 3..NUM_TAPS+2: LOAD.
  - Cycle NUM_TAPS+3: COMMIT (`coeff_ld`, `load_done`).
  - Cycle NUM_TAPS+4: IDLE, with `gate`=0 and `host_ready`=1.
- An upstream transfer in the commit cycle itself is legal. The resulting `fir_busy` simply extends DRAIN.
- `up_ready` and `fir_data_valid` are combinational from registered `gate`. Exactly zero transfers occur from cycle 1 through cycle NUM_TAPS+3.
- Timeout abort: `err_timeout`=1 and state IDLE on the cycle after the DRAIN counter reaches `DRAIN_TIMEOUT`.

## Test plan
- **Basic load:** write shadow[i]=i+1 for i=0..63, commit with `fir_busy`=0.
  - `coeff_wr` is high for exactly 64 consecutive cycles starting cycle 3, with addr/data 0/1 through 63/64.
  - `coeff_ld` and `load_done` pulse at cycle 67; `gen_count`=1.
- **Busy drain:** hold `fir_busy`=1 for 10 cycles after commit.
  - LOAD starts 2 cycles after `fir_busy` falls.
  - `up_ready`=0 and no `fir_data_valid` throughout.
- **Timeout:** `DRAIN_TIMEOUT`=16 with `fir_busy` stuck at 1.
  - `err_timeout`=1, zero `coeff_wr` pulses, `gate` released.
  - After `err_clr`, `err_timeout` reads 0.
- **Illegal accesses:**
  - `host_wr` to addr 64: `err_addr`=1 and no shadow change.
  - `cmd_commit` during LOAD: `err_busy`=1 and exactly one load completes.
- **Same-cycle write and commit:** `host_wr` addr 5 data 0x3FFFF with `cmd_commit` in the same cycle. The load shows addr 5 data 0x3FFFF.
- **Reset and wrap:** assert `rst` at LOAD index 20.
  - Next cycle: IDLE, `coeff_wr`=0, shadow reads 0, `gen_count`=0.
  - 256 further commits wrap `gen_count` to 0.
